// File: rtl/audio_pkg.sv
// Shared constants and parameter sanity check for the codec serial interface.
package audio_pkg;

    localparam logic FMT_LJ   = 1'b0;
    localparam logic FMT_I2S  = 1'b1;
    localparam int   CH_LEFT  = 1;
    localparam int   CH_RIGHT = 0;

    function automatic bit params_ok(input int sample_w, input int bclk_div, input int slot_bits);
        return (sample_w >= 1) && (sample_w <= 32) &&
               (bclk_div >= 2) && (bclk_div % 2 == 0) &&
               (slot_bits >= sample_w + 1);
    endfunction

endpackage

// File: rtl/audio_clkgen.sv
// BCLK/LRCK generator with phase, bit-position and slot counters.
// Strobes are asserted in the cycle before the clk edge they describe.
module audio_clkgen
    import audio_pkg::*;
#(
    parameter int BCLK_DIV       = 4,
    parameter int SLOT_BITS      = 32,
    parameter bit LRCK_LEFT_HIGH = 1'b1,
    localparam int PW            = $clog2(SLOT_BITS)
)(
    input  logic          clk,
    input  logic          reset,
    output logic          bclk,
    output logic          lrck,
    output logic          rise_stb,
    output logic          fall_stb,
    output logic          frame_start_pre,
    output logic          ready_pre,
    output logic          slot,
    output logic [PW-1:0] pos,
    output logic          slot_nxt,
    output logic [PW-1:0] pos_nxt
);

    localparam int            DW       = $clog2(BCLK_DIV);
    localparam logic [DW-1:0] PH_RISE  = DW'(BCLK_DIV / 2 - 1);
    localparam logic [DW-1:0] PH_FALL  = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] PH_READY = DW'(BCLK_DIV - 2);
    localparam logic [PW-1:0] POS_LAST = PW'(SLOT_BITS - 1);
    localparam logic          SLOT_L   = 1'(CH_LEFT);
    localparam logic          SLOT_R   = 1'(CH_RIGHT);

    logic [DW-1:0] phase;
    logic          last_pos;

    always_comb begin
        rise_stb        = (phase == PH_RISE);
        fall_stb        = (phase == PH_FALL);
        last_pos        = (pos == POS_LAST);
        pos_nxt         = last_pos ? '0 : pos + 1'b1;
        slot_nxt        = last_pos ? ~slot : slot;
        frame_start_pre = fall_stb && last_pos && (slot == SLOT_R);
        ready_pre       = (phase == PH_READY) && last_pos && (slot == SLOT_R);
    end

    // Reset parks on the last right-slot bit so the first fall edge opens a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
            pos   <= POS_LAST;
            slot  <= SLOT_R;
            bclk  <= 1'b0;
            lrck  <= ~LRCK_LEFT_HIGH;
        end else begin
            phase <= fall_stb ? '0 : phase + 1'b1;
            if (rise_stb)
                bclk <= 1'b1;
            if (fall_stb) begin
                bclk <= 1'b0;
                pos  <= pos_nxt;
                slot <= slot_nxt;
                lrck <= (slot_nxt == SLOT_L) ? LRCK_LEFT_HIGH : ~LRCK_LEFT_HIGH;
            end
        end
    end

endmodule

// File: rtl/audio_codec_if.sv
// Master-mode stereo serial audio interface: DAC serialiser with frame
// handshake/underrun tracking and ADC deserialiser, LJ or I2S framing.
module audio_codec_if
    import audio_pkg::*;
#(
    parameter int SAMPLE_W       = 16,
    parameter int BCLK_DIV       = 4,
    parameter int SLOT_BITS      = 32,
    parameter bit LRCK_LEFT_HIGH = 1'b1
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fmt_i2s,
    input  logic [1:0]            ch_en,
    input  logic [2*SAMPLE_W-1:0] dac_data,
    input  logic                  dac_valid,
    output logic                  dac_ready,
    output logic [2*SAMPLE_W-1:0] adc_data,
    output logic                  adc_valid,
    output logic                  underrun,
    input  logic                  underrun_clr,
    output logic                  AUD_BCLK,
    output logic                  AUD_DACLRCK,
    output logic                  AUD_ADCLRCK,
    output logic                  AUD_DACDAT,
    input  logic                  AUD_ADCDAT
);

    localparam int   PW     = $clog2(SLOT_BITS);
    localparam logic SLOT_L = 1'(CH_LEFT);
    localparam logic SLOT_R = 1'(CH_RIGHT);

    if (!params_ok(SAMPLE_W, BCLK_DIV, SLOT_BITS)) begin : g_bad_params
        $error("audio_codec_if: invalid SAMPLE_W/BCLK_DIV/SLOT_BITS combination");
    end

    logic          lrck, rise_stb, fall_stb, frame_start_pre, ready_pre;
    logic          slot, slot_nxt;
    logic [PW-1:0] pos, pos_nxt;

    audio_clkgen #(
        .BCLK_DIV       (BCLK_DIV),
        .SLOT_BITS      (SLOT_BITS),
        .LRCK_LEFT_HIGH (LRCK_LEFT_HIGH)
    ) u_clkgen (
        .clk             (clk),
        .reset           (reset),
        .bclk            (AUD_BCLK),
        .lrck            (lrck),
        .rise_stb        (rise_stb),
        .fall_stb        (fall_stb),
        .frame_start_pre (frame_start_pre),
        .ready_pre       (ready_pre),
        .slot            (slot),
        .pos             (pos),
        .slot_nxt        (slot_nxt),
        .pos_nxt         (pos_nxt)
    );

    assign AUD_DACLRCK = lrck;
    assign AUD_ADCLRCK = lrck;

    function automatic int data_off(input logic fmt);
        return (fmt == FMT_I2S) ? 1 : 0;
    endfunction

    function automatic logic slot_bit(input logic [SAMPLE_W-1:0] s, input logic fmt, input int p);
        logic [SAMPLE_W-1:0] sh;
        int d;
        d = data_off(fmt);
        if (p < d || p >= d + SAMPLE_W)
            return 1'b0;
        sh = s >> (SAMPLE_W - 1 - (p - d));
        return sh[0];
    endfunction

    function automatic logic [SAMPLE_W-1:0] put_bit(input logic [SAMPLE_W-1:0] s, input logic fmt,
                                                    input int p, input logic b);
        logic [SAMPLE_W-1:0] mask;
        int d;
        d = data_off(fmt);
        if (p < d || p >= d + SAMPLE_W)
            return s;
        mask = SAMPLE_W'(1) << (SAMPLE_W - 1 - (p - d));
        return b ? (s | mask) : (s & ~mask);
    endfunction

    logic [SAMPLE_W-1:0] held_l, held_r, nxt_l, nxt_r, tx;
    logic [SAMPLE_W-1:0] cap_l, cap_r, cap_l_nxt, cap_r_nxt, adc_l, adc_r;
    logic                fmt_q, nxt_fmt, take, dac_bit, last_adc, armed;
    logic [1:0]          en_q, nxt_en;

    // The frame-start fall edge must already see the newly accepted frame and
    // settings, so the serialiser looks through the latches on that edge.
    always_comb begin
        take    = frame_start_pre && dac_valid && dac_ready;
        nxt_l   = take ? dac_data[2*SAMPLE_W-1:SAMPLE_W] : held_l;
        nxt_r   = take ? dac_data[SAMPLE_W-1:0] : held_r;
        nxt_fmt = frame_start_pre ? fmt_i2s : fmt_q;
        nxt_en  = frame_start_pre ? ch_en : en_q;

        if (slot_nxt == SLOT_L)
            tx = nxt_en[CH_LEFT] ? nxt_l : (nxt_en[CH_RIGHT] ? nxt_r : '0);
        else
            tx = nxt_en[CH_RIGHT] ? nxt_r : (nxt_en[CH_LEFT] ? nxt_l : '0);
        dac_bit = slot_bit(tx, nxt_fmt, int'(pos_nxt));

        cap_l_nxt = cap_l;
        cap_r_nxt = cap_r;
        if (rise_stb) begin
            if (slot == SLOT_L)
                cap_l_nxt = put_bit(cap_l, fmt_q, int'(pos), AUD_ADCDAT);
            else
                cap_r_nxt = put_bit(cap_r, fmt_q, int'(pos), AUD_ADCDAT);
        end
        last_adc = armed && rise_stb && (slot == SLOT_R) &&
                   (int'(pos) == data_off(fmt_q) + SAMPLE_W - 1);
        adc_l    = en_q[CH_LEFT]  ? cap_l_nxt : '0;
        adc_r    = en_q[CH_RIGHT] ? cap_r_nxt : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dac_ready  <= 1'b0;
            adc_valid  <= 1'b0;
            adc_data   <= '0;
            underrun   <= 1'b0;
            AUD_DACDAT <= 1'b0;
            held_l     <= '0;
            held_r     <= '0;
            cap_l      <= '0;
            cap_r      <= '0;
            fmt_q      <= FMT_LJ;
            en_q       <= '0;
            armed      <= 1'b0;
        end else begin
            dac_ready <= ready_pre;
            adc_valid <= last_adc;
            cap_l     <= cap_l_nxt;
            cap_r     <= cap_r_nxt;
            if (last_adc)
                adc_data <= {adc_l, adc_r};
            if (fall_stb)
                AUD_DACDAT <= dac_bit;
            // armed keeps the partial frame left over from reset from reporting
            if (frame_start_pre) begin
                held_l <= nxt_l;
                held_r <= nxt_r;
                fmt_q  <= fmt_i2s;
                en_q   <= ch_en;
                armed  <= 1'b1;
            end
            if (frame_start_pre && !take)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_codec_if.sv
// Bench for audio_codec_if: loopback vectors, serial slot monitor, handshake,
// reset and wide-sample configuration checks.
module tb_audio_codec_if;

    localparam int SW = 16, DIV = 4, SB = 32;

    logic        clk = 1'b0, reset = 1'b1;
    logic        fmt_i2s = 1'b0, dac_valid = 1'b1, underrun_clr = 1'b0;
    logic [1:0]  ch_en = 2'b11;
    logic [31:0] dac_data = 32'hA5C3_3C5A;
    logic [31:0] adc_data;
    logic        dac_ready, adc_valid, underrun, bclk, dlrck, alrck, dacdat, adcdat;

    logic [47:0] u2_dac_data = {24'hF0F0F0, 24'h0F0F0F};
    logic [47:0] u2_adc_data;
    logic        u2_fmt = 1'b0, u2_valid = 1'b1, u2_clr = 1'b0;
    logic [1:0]  u2_en = 2'b11;
    logic        u2_ready, u2_adc_valid, u2_underrun, u2_bclk, u2_dlrck, u2_alrck, u2_dacdat, u2_adcdat;

    assign adcdat    = dacdat;
    assign u2_adcdat = u2_dacdat;

    always #5 clk = ~clk;

    audio_codec_if dut (
        .clk(clk), .reset(reset), .fmt_i2s(fmt_i2s), .ch_en(ch_en),
        .dac_data(dac_data), .dac_valid(dac_valid), .dac_ready(dac_ready),
        .adc_data(adc_data), .adc_valid(adc_valid), .underrun(underrun),
        .underrun_clr(underrun_clr), .AUD_BCLK(bclk), .AUD_DACLRCK(dlrck),
        .AUD_ADCLRCK(alrck), .AUD_DACDAT(dacdat), .AUD_ADCDAT(adcdat)
    );

    audio_codec_if #(.SAMPLE_W(24), .BCLK_DIV(8), .SLOT_BITS(32), .LRCK_LEFT_HIGH(1'b1)) u2 (
        .clk(clk), .reset(reset), .fmt_i2s(u2_fmt), .ch_en(u2_en),
        .dac_data(u2_dac_data), .dac_valid(u2_valid), .dac_ready(u2_ready),
        .adc_data(u2_adc_data), .adc_valid(u2_adc_valid), .underrun(u2_underrun),
        .underrun_clr(u2_clr), .AUD_BCLK(u2_bclk), .AUD_DACLRCK(u2_dlrck),
        .AUD_ADCLRCK(u2_alrck), .AUD_DACDAT(u2_dacdat), .AUD_ADCDAT(u2_adcdat)
    );

    // Serial monitor: rebuilds each slot's bit vector from the pins (bit p = position p).
    logic [SB-1:0] mon_cur = '0, mon_l = '0, mon_r = '0;
    logic          mon_lr = 1'b0;
    int            mon_pos = 0, mon_frames = 0;

    always @(posedge bclk) begin
        if (dlrck != mon_lr) begin
            if (mon_lr) mon_l <= mon_cur;
            else begin
                mon_r      <= mon_cur;
                mon_frames <= mon_frames + 1;
            end
            mon_cur <= SB'(dacdat);
            mon_pos <= 1;
            mon_lr  <= dlrck;
        end else begin
            mon_cur <= mon_cur | (SB'(dacdat) << mon_pos);
            mon_pos <= mon_pos + 1;
        end
    end

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event within budget, expected one", name);
    endtask

    // Reference model, straight from the framing rules.
    function automatic logic [SW-1:0] tx_sample(input logic [1:0] en, input logic [31:0] d, input bit left);
        logic [SW-1:0] l, r;
        l = d[31:16];
        r = d[15:0];
        if (left) return en[1] ? l : (en[0] ? r : '0);
        return en[0] ? r : (en[1] ? l : '0);
    endfunction

    function automatic logic [SB-1:0] slot_vec(input logic [SW-1:0] s, input logic fmt);
        logic [SB-1:0] v;
        v = '0;
        for (int i = 0; i < SW; i++)
            if (((s >> i) & 1) != 0) v = v | (SB'(1) << ((fmt ? 1 : 0) + SW - 1 - i));
        return v;
    endfunction

    function automatic logic [31:0] adc_model(input logic [1:0] en, input logic [31:0] d);
        return {en[1] ? d[31:16] : 16'h0, en[0] ? d[15:0] : 16'h0};
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (dac_ready) begin ok = 1; return; end
        end
        timeout("dac_ready");
    endtask

    task automatic wait_adc(input bit big, output bit ok);
        ok = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (big ? u2_adc_valid : adc_valid) begin ok = 1; return; end
        end
        timeout("adc_valid");
    endtask

    task automatic wait_mon(input int target, output bit ok);
        ok = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (mon_frames >= target) begin ok = 1; return; end
        end
        timeout("serial_frame");
    endtask

    task automatic adc_gap(input bit big, output int n);
        n = -1;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge clk);
            if (big ? u2_adc_valid : adc_valid) begin n = i; return; end
        end
    endtask

    task automatic check_serial(input logic fmt, input logic [1:0] en, input logic [31:0] d);
        check("dac_left_slot", mon_l, slot_vec(tx_sample(en, d, 1'b1), fmt));
        check("dac_right_slot", mon_r, slot_vec(tx_sample(en, d, 1'b0), fmt));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bclk"}, bclk, 1'b0);
        check({tag, "_lrck"}, {dlrck, alrck}, 2'b00);
        check({tag, "_dacdat"}, dacdat, 1'b0);
        check({tag, "_dac_ready"}, dac_ready, 1'b0);
        check({tag, "_adc_valid"}, adc_valid, 1'b0);
        check({tag, "_adc_data"}, adc_data, 32'h0);
        check({tag, "_underrun"}, underrun, 1'b0);
    endtask

    typedef struct {
        logic        fmt;
        logic [1:0]  en;
        logic [31:0] data;
        logic [31:0] exp_adc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit   ok;
        int   n, f0, t1, t2, rdy_n, adc_n;
        logic prev;

        vecs.push_back('{1'b0, 2'b11, 32'hA5C3_3C5A, 32'hA5C3_3C5A});
        vecs.push_back('{1'b1, 2'b11, 32'h8001_0001, 32'h8001_0001});
        vecs.push_back('{1'b0, 2'b10, 32'hBEEF_0000, 32'hBEEF_0000});
        vecs.push_back('{1'b1, 2'b01, 32'h1111_2222, 32'h0000_2222});
        vecs.push_back('{1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0000_0000});
        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v.fmt     = 1'($urandom_range(0, 1));
            v.en      = 2'($urandom_range(0, 3));
            v.data    = $urandom;
            v.exp_adc = adc_model(v.en, v.data);
            vecs.push_back(v);
        end

        // Reset state and first-frame latency
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (dac_ready) begin n = i; break; end
        end
        check("first_ready_latency", n, DIV - 1);

        // First full frame loops back, then frames repeat every 256 cycles
        wait_adc(1'b0, ok);
        if (ok) check("first_adc_data", adc_data, 32'hA5C3_3C5A);
        adc_gap(1'b0, n);
        check("adc_gap", n, 2 * SB * DIV);
        adc_gap(1'b0, n);
        check("adc_gap2", n, 2 * SB * DIV);

        foreach (vecs[k]) begin
            wait_ready(ok);
            if (!ok) continue;
            fmt_i2s   = vecs[k].fmt;
            ch_en     = vecs[k].en;
            dac_data  = vecs[k].data;
            dac_valid = 1'b1;
            f0        = mon_frames;
            wait_adc(1'b0, ok);
            if (ok) check("vec_adc_data", adc_data, vecs[k].exp_adc);
            wait_mon(f0 + 2, ok);
            if (ok) check_serial(vecs[k].fmt, vecs[k].en, vecs[k].data);
        end
        check("underrun_idle", underrun, 1'b0);

        // Missing frame: replay previous held frame and raise underrun
        wait_ready(ok);
        fmt_i2s  = 1'b0;
        ch_en    = 2'b11;
        dac_data = 32'h1234_5678;
        @(negedge clk);
        dac_valid = 1'b0;
        dac_data  = 32'hDEAD_BEEF;
        wait_adc(1'b0, ok);
        if (ok) check("pre_underrun_adc", adc_data, 32'h1234_5678);
        wait_ready(ok);
        f0 = mon_frames;
        @(negedge clk);
        check("underrun_set", underrun, 1'b1);
        wait_adc(1'b0, ok);
        if (ok) check("replay_adc", adc_data, 32'h1234_5678);
        wait_mon(f0 + 2, ok);
        if (ok) check_serial(1'b0, 2'b11, 32'h1234_5678);
        dac_valid = 1'b1;
        dac_data  = 32'h1234_5678;
        repeat (10) @(negedge clk);
        check("underrun_sticky", underrun, 1'b1);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check("underrun_cleared", underrun, 1'b0);

        // Set and clear in the same cycle: set wins
        wait_ready(ok);
        dac_valid    = 1'b0;
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        dac_valid    = 1'b1;
        check("underrun_set_wins", underrun, 1'b1);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check("underrun_cleared2", underrun, 1'b0);

        // Reset in the middle of the left slot
        wait_ready(ok);
        dac_data = 32'hA5C3_3C5A;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("midreset");
        reset = 1'b0;
        rdy_n = -1;
        adc_n = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (dac_ready && rdy_n < 0) rdy_n = i;
            if (adc_valid) begin adc_n = i; break; end
        end
        check("midreset_ready_latency", rdy_n, DIV - 1);
        check("midreset_first_adc", adc_n, DIV + (SB + SW - 1) * DIV + DIV / 2);
        check("midreset_adc_data", adc_data, 32'hA5C3_3C5A);

        // Wide configuration: 24-bit samples, BCLK_DIV=8
        t1 = -1;
        t2 = -1;
        prev = u2_bclk;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!prev && u2_bclk) begin
                if (t1 < 0) t1 = i;
                else begin t2 = i; break; end
            end
            prev = u2_bclk;
        end
        check("u2_bclk_period", t2 - t1, 8);
        wait_adc(1'b1, ok);
        if (ok) check("u2_adc_data", u2_adc_data, {24'hF0F0F0, 24'h0F0F0F});
        adc_gap(1'b1, n);
        check("u2_adc_gap", n, 512);
        check("u2_adc_data2", u2_adc_data, {24'hF0F0F0, 24'h0F0F0F});
        check("u2_underrun", u2_underrun, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_codec_if.md
Name: audio_codec_if

Overview:
- Parametrised master-mode serial audio interface for the board codec; drives BCLK/LRCK and serialises a stereo DAC frame while deserialising a stereo ADC frame.
- Successor to the fixed 16-bit left-justified driver:
  - adds configurable sample width, clock ratio and slot length;
  - adds runtime I2S vs left-justified framing;
  - adds a valid/ready frame handshake with underrun detection, and per-channel enables.
- Sits between effect pipeline and codec pins.

Parameters:
- SAMPLE_W, 16, bits per channel sample (1..32).
- BCLK_DIV, 4, clk cycles per BCLK period (even, >=2).
- SLOT_BITS, 32, BCLK periods per channel slot (>= SAMPLE_W+1).
- LRCK_LEFT_HIGH, 1, LRCK level during left slot.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- fmt_i2s  in  1  1 = I2S (one-BCLK delay), 0 = left-justified; sampled at frame start
- ch_en  in  2  [1] = left enable, [0] = right enable; sampled at frame start
- dac_data  in  2*SAMPLE_W  {left,right} playback frame
- dac_valid  in  1  dac_data valid
- dac_ready  out  1  one-cycle frame-accept strobe
- adc_data  out  2*SAMPLE_W  {left,right} captured frame
- adc_valid  out  1  one-cycle capture strobe
- underrun  out  1  sticky: frame start without a DAC frame
- underrun_clr  in  1  clears underrun
- AUD_BCLK  out  1  bit clock
- AUD_DACLRCK, AUD_ADCLRCK  out  1  shared LR clock
- AUD_DACDAT  out  1  serial playback data
- AUD_ADCDAT  in  1  serial capture data

Behaviour:

Reset:
- AUD_BCLK=0; LRCK = right-slot level; AUD_DACDAT=0.
- dac_ready=0, adc_valid=0, adc_data=0, underrun=0.
- Held frame = 0.
- Counters preset to right slot, position SLOT_BITS-1, phase 0.
- First frame-start edge is the BCLK_DIV-th clk edge after reset deasserts.
- Reset mid-frame aborts immediately; no adc_valid for a partial frame.

Timing (all outputs registered):
- Phase counter runs 0..BCLK_DIV-1. BCLK is low for phases 0..BCLK_DIV/2-1 and high otherwise.
- Rise edge = clk edge where AUD_BCLK goes 0->1. Fall edge = where it goes 1->0.
- Position p counts 0..SLOT_BITS-1 and advances on fall edges. Slot toggles left/right after p=SLOT_BITS-1.
- LRCK changes on the fall edge that starts p=0 of each slot.
- Frame = 2*SLOT_BITS*BCLK_DIV clk cycles; the defaults give 256.

Data mapping:
- Offset D = fmt_i2s ? 1 : 0.
- For D <= p < D+SAMPLE_W, slot bit index is SAMPLE_W-1-(p-D), MSB first.
- Outside that window AUD_DACDAT = 0 and AUD_ADCDAT is ignored.
- DAC bit is updated on the fall edge that starts position p.
- ADC bit is sampled on the rise edge within position p.

DAC handshake:
- dac_ready is high exactly one cycle: the cycle before the frame-start fall edge (left slot, p=0).
- dac_valid && dac_ready in that cycle: dac_data becomes the held frame for this frame.
- Otherwise the previous held frame is replayed and underrun is set.
- underrun clears on underrun_clr. If set and clear coincide, set wins.
- dac_valid outside the ready cycle has no effect.

Channel enables:
- A disabled channel's DAC slot transmits the other channel's held sample (mirror).
- Both channels disabled: DACDAT = 0.
- A disabled channel's ADC half of adc_data is 0.

ADC capture:
- adc_valid pulses for one cycle, the clk cycle after the rise edge of right-slot position D+SAMPLE_W-1.
- adc_data updates in the same cycle as adc_valid and holds until the next pulse.
- adc_valid does not depend on dac activity.

fmt_i2s and ch_en changes take effect only at the next frame start.

Decomposition:
- Package audio_pkg holds:
  - format constants (FMT_LJ=0, FMT_I2S=1);
  - channel index constants (CH_LEFT=1, CH_RIGHT=0);
  - a compile-time check function for the parameter constraints.
- One sub-module, audio_clkgen:
  - phase/position/slot counters, BCLK, LRCK;
  - strobes rise_stb, fall_stb, frame_start_pre, slot, pos.
- Serialiser, deserialiser and handshake live in audio_codec_if.

Test Plan (defaults unless noted):
- Left-justified loopback (DACDAT wired to ADCDAT), dac_valid held with {16'hA5C3,16'h3C5A} -> first complete adc_valid shows adc_data=={16'hA5C3,16'h3C5A}; consecutive adc_valid pulses exactly 256 cycles apart; underrun stays 0.
- fmt_i2s=1, dac_data={16'h8001,16'h0001} -> left MSB '1' appears at p=1 (one BCLK after LRCK edge); bits at p=0 and p>=17 are 0.
- dac_valid deasserted for one frame after {16'h1234,16'h5678} -> that frame retransmits 1234/5678; underrun=1 until underrun_clr pulse; set+clear in the same cycle leaves underrun=1.
- ch_en=2'b10, dac_data={16'hBEEF,16'h0000} -> right slot transmits BEEF; loopback adc_data=={16'hBEEF,16'h0000}.
- SAMPLE_W=24, BCLK_DIV=8, SLOT_BITS=32 -> BCLK period 8 cycles, frame 512 cycles; 24'hF0F0F0 round-trips in loopback.
- Reset asserted mid-left-slot for 3 cycles -> outputs return to reset values; no adc_valid until a full new frame completes; dac_ready recurs at cycle BCLK_DIV-1 after release.
